page_fetch_scheduler: RTL and testbench
=======================================

PAGE_FETCH_SCHEDULER -- requirements
Module: page_fetch_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd48000, is the MCLK cycles allowed between FETCH_ACK and FETCH_DONE.
REQ-002 Parameter BOOT_ADDR, default 12'd0, is the FETCH_ADDR used for bootloader fetches.
REQ-003 MCLK  in  1  48 MHz master clock; all state changes on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 ACCTYPE  in  3  access type from timing generator: 000 RST, 001 STBY, 110 BOOT, 111 USER, 100 IDLE.
REQ-006 ABSPOS  in  12  absolute bubble position, range 0-2052.
REQ-007 BOUTCYCLENUM  in  13  output cycle number; 13'h1FFF means no valid output cycle.
REQ-008 FETCH_REQ  out  1  fetch request to flash loader.
REQ-009 FETCH_TYPE  out  1  0 = bootloader, 1 = page.
REQ-010 FETCH_ADDR  out  12  page position to fetch.
REQ-011 FETCH_BANK  out  1  buffer bank the loader writes.
REQ-012 FETCH_ACK  in  1  loader accepted request.
REQ-013 FETCH_DONE  in  1  one-cycle pulse: loader finished writing FETCH_BANK.
REQ-014 READ_BANK  out  1  buffer bank the bubble output path reads.
REQ-015 BUF_VALID  out  1  READ_BANK holds data for current access.
REQ-016 UNDERRUN  out  1  sticky error flag.

Function
REQ-017 States: S_IDLE, S_REQ, S_WAIT, S_ERR (the last only with the macro of REQ-031).
REQ-018 Trigger BOOT: ACCTYPE becomes 110 from any other value (registered previous ACCTYPE compared).
REQ-019 Trigger PAGE: ACCTYPE becomes 111 from any other value; ABSPOS sampled on that same cycle.
REQ-020 On trigger in S_IDLE: latch TYPE/ADDR (BOOT_ADDR or sampled ABSPOS), toggle FETCH_BANK, clear BUF_VALID, go S_REQ; FETCH_REQ high the next cycle.
REQ-021 S_REQ: FETCH_REQ, FETCH_TYPE, FETCH_ADDR, FETCH_BANK held stable until FETCH_ACK sampled high; then FETCH_REQ low next cycle, go S_WAIT.
REQ-022 FETCH_ACK and FETCH_DONE high in the same cycle in S_REQ: treated as ack followed by done; go S_IDLE directly.
REQ-023 On FETCH_DONE in S_WAIT: READ_BANK <= FETCH_BANK, BUF_VALID <= 1, go S_IDLE.
REQ-024 Trigger while in S_REQ/S_WAIT: stored in a one-deep pending slot (latest overwrites), issued on the cycle after return to S_IDLE.
REQ-025 ACCTYPE = 000 during S_REQ/S_WAIT: handshake completes, but the result is discarded (no READ_BANK change, BUF_VALID stays 0); the pending slot is cleared.
REQ-026 ACCTYPE = 000 in any state: BUF_VALID <= 0, UNDERRUN <= 0.
REQ-027 UNDERRUN set when BOUTCYCLENUM changes from 13'h1FFF to any other value while BUF_VALID = 0; it holds until reset or ACCTYPE = 000.
REQ-028 FETCH_ADDR passes ABSPOS unmodified; values above 2052 are not corrected.

Reset
REQ-029 RST high, asynchronously: state S_IDLE, FETCH_REQ 0, FETCH_TYPE 0, FETCH_ADDR BOOT_ADDR, FETCH_BANK 1, READ_BANK 0, BUF_VALID 0, UNDERRUN 0, pending empty, previous ACCTYPE 000, timeout counter 0.
REQ-030 First trigger after reset writes bank 0.

Configuration
REQ-031 Macro PFS_FETCH_TIMEOUT_EN defined: a 16-bit counter runs in S_WAIT, cleared on entry, saturating at 16'hFFFF.
- When the counter reaches TIMEOUT_CYC it sets UNDERRUN and the block enters S_ERR.
- S_ERR exits to S_IDLE only when ACCTYPE = 000, with the pending slot cleared.
- A late FETCH_DONE in S_ERR is ignored.
REQ-032 Macro undefined: no counter and no S_ERR; S_WAIT waits for FETCH_DONE indefinitely.

Structure
REQ-033 Shared package bubble_pkg holds:
- the ACCTYPE encodings (RST, STBY, BOOT, USER, IDLE);
- the scheduler state enum;
- 13'h1FFF as BOUT_NONE;
- 12'd2052 as ABSPOS_MAX.
REQ-034 Sub-module fetch_handshake (S_REQ/S_WAIT request/ack/done tracking plus optional timeout) is instantiated once; edge detection and the pending slot stay in the top module.

Verification
REQ-035 After reset, ACCTYPE 000->001->110 -> FETCH_REQ=1, TYPE=0, ADDR=0, BANK=0; ACK then DONE -> READ_BANK=0, BUF_VALID=1.
REQ-036 ACCTYPE ->100 then ->111 with ABSPOS=1234 -> FETCH_ADDR=1234, TYPE=1, BANK toggled; READ_BANK follows after DONE.
REQ-037 Second PAGE trigger (ABSPOS=7) during S_WAIT, then third (ABSPOS=9) -> after first DONE, exactly one new request with ADDR=9.
REQ-038 BOUTCYCLENUM 1FFF->0 before FETCH_DONE -> UNDERRUN=1; ACCTYPE=000 -> UNDERRUN=0.
REQ-039 ACCTYPE=000 mid-S_WAIT, then DONE -> BUF_VALID=0, READ_BANK unchanged; ACK and DONE in the same cycle -> S_IDLE in one step.
REQ-040 With PFS_FETCH_TIMEOUT_EN and TIMEOUT_CYC=100, no DONE -> UNDERRUN=1 at the 100th S_WAIT cycle, state S_ERR; without the macro the block stays in S_WAIT.

Source files
------------

// File: rtl/bubble_pkg.sv
// Shared encodings for the bubble-memory emulator: ACCTYPE codes, scheduler
// states and the output-cycle / position limits.
package bubble_pkg;

  typedef enum logic [2:0] {
    ACC_RST  = 3'b000,
    ACC_STBY = 3'b001,
    ACC_IDLE = 3'b100,
    ACC_BOOT = 3'b110,
    ACC_USER = 3'b111
  } acctype_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } sched_state_t;

  localparam logic [12:0] BOUT_NONE  = 13'h1FFF;
  localparam logic [11:0] ABSPOS_MAX = 12'd2052;

  localparam logic FT_BOOT = 1'b0;
  localparam logic FT_PAGE = 1'b1;

endpackage

// File: rtl/fetch_handshake.sv
// Request/ack/done tracking for one flash-loader fetch. With PFS_FETCH_TIMEOUT_EN
// defined, a stalled loader is caught by a saturating wait counter and S_ERR.
module fetch_handshake
  import bubble_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd48000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         fetch_ack,
  input  logic         fetch_done,
  output sched_state_t state,
  output logic         fetch_req,
  output logic         commit,
  output logic         timeout
);

  // Set when ACCTYPE returns to RST mid-fetch; the loader still finishes, but
  // its data must not become the read bank.
  logic discard;
  logic done_seen;

  always_comb begin
    done_seen = fetch_done && ((state == S_REQ && fetch_ack) || state == S_WAIT);
    commit    = done_seen && !discard && !abort;
  end

`ifdef PFS_FETCH_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic [15:0] cnt_inc;

  always_comb begin
    cnt_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
    timeout = (state == S_WAIT) && !fetch_done && (cnt_inc >= TIMEOUT_CYC);
  end
`else
  logic unused_cfg;

  // No wait counter in this build: the loader may take as long as it needs.
  assign unused_cfg = ^TIMEOUT_CYC;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      fetch_req <= 1'b0;
      discard   <= 1'b0;
`ifdef PFS_FETCH_TIMEOUT_EN
      wait_cnt  <= 16'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_REQ;
            fetch_req <= 1'b1;
            discard   <= 1'b0;
          end
        end
        S_REQ: begin
          if (abort) discard <= 1'b1;
          if (fetch_ack) begin
            fetch_req <= 1'b0;
            state     <= fetch_done ? S_IDLE : S_WAIT;
`ifdef PFS_FETCH_TIMEOUT_EN
            wait_cnt  <= 16'd0;
`endif
          end
        end
        S_WAIT: begin
          if (abort) discard <= 1'b1;
          if (fetch_done) begin
            state <= S_IDLE;
          end else begin
`ifdef PFS_FETCH_TIMEOUT_EN
            wait_cnt <= cnt_inc;
            if (timeout) state <= S_ERR;
`endif
          end
        end
        S_ERR: begin
          if (abort) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/page_fetch_scheduler.sv
// Turns BOOT/USER access edges into flash-loader fetches into a double buffer
// and flags output-path underruns. Optional loader timeout: PFS_FETCH_TIMEOUT_EN.
module page_fetch_scheduler
  import bubble_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd48000,
  parameter logic [11:0] BOOT_ADDR   = 12'd0
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic [2:0]  ACCTYPE,
  input  logic [11:0] ABSPOS,
  input  logic [12:0] BOUTCYCLENUM,
  output logic        FETCH_REQ,
  output logic        FETCH_TYPE,
  output logic [11:0] FETCH_ADDR,
  output logic        FETCH_BANK,
  input  logic        FETCH_ACK,
  input  logic        FETCH_DONE,
  output logic        READ_BANK,
  output logic        BUF_VALID,
  output logic        UNDERRUN
);

  logic [2:0]   acc_prev;
  logic [12:0]  bout_prev;
  logic         boot_trig, page_trig, trig;
  logic         trig_type;
  logic [11:0]  trig_addr;
  logic         pend_vld, pend_type;
  logic [11:0]  pend_addr;
  logic         idle, start, start_type;
  logic [11:0]  start_addr;
  logic         abort, commit, timeout, bout_start;
  sched_state_t state;

  always_comb begin
    abort      = (ACCTYPE == ACC_RST);
    boot_trig  = (ACCTYPE == ACC_BOOT) && (acc_prev != ACC_BOOT);
    page_trig  = (ACCTYPE == ACC_USER) && (acc_prev != ACC_USER);
    trig       = boot_trig || page_trig;
    trig_type  = page_trig ? FT_PAGE : FT_BOOT;
    trig_addr  = page_trig ? ABSPOS : BOOT_ADDR;
    idle       = (state == S_IDLE);
    // A fresh trigger is newer than anything parked in the pending slot.
    start      = idle && (trig || pend_vld);
    start_type = trig ? trig_type : pend_type;
    start_addr = trig ? trig_addr : pend_addr;
    bout_start = (bout_prev == BOUT_NONE) && (BOUTCYCLENUM != BOUT_NONE);
  end

  fetch_handshake #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_handshake (
    .clk        (MCLK),
    .rst        (RST),
    .start      (start),
    .abort      (abort),
    .fetch_ack  (FETCH_ACK),
    .fetch_done (FETCH_DONE),
    .state      (state),
    .fetch_req  (FETCH_REQ),
    .commit     (commit),
    .timeout    (timeout)
  );

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      acc_prev   <= ACC_RST;
      bout_prev  <= BOUT_NONE;
      pend_vld   <= 1'b0;
      pend_type  <= FT_BOOT;
      pend_addr  <= BOOT_ADDR;
      FETCH_TYPE <= FT_BOOT;
      FETCH_ADDR <= BOOT_ADDR;
      FETCH_BANK <= 1'b1;
      READ_BANK  <= 1'b0;
      BUF_VALID  <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      acc_prev  <= ACCTYPE;
      bout_prev <= BOUTCYCLENUM;

      // Pending slot: one deep, only filled while a fetch is in flight.
      if (abort) begin
        pend_vld <= 1'b0;
      end else if (trig && (state == S_REQ || state == S_WAIT)) begin
        pend_vld  <= 1'b1;
        pend_type <= trig_type;
        pend_addr <= trig_addr;
      end else if (start) begin
        pend_vld <= 1'b0;
      end

      if (start) begin
        FETCH_TYPE <= start_type;
        FETCH_ADDR <= start_addr;
        FETCH_BANK <= ~FETCH_BANK;
      end

      if (commit) READ_BANK <= FETCH_BANK;

      if (abort)       BUF_VALID <= 1'b0;
      else if (start)  BUF_VALID <= 1'b0;
      else if (commit) BUF_VALID <= 1'b1;

      if (abort)                         UNDERRUN <= 1'b0;
      else if (timeout)                  UNDERRUN <= 1'b1;
      else if (bout_start && !BUF_VALID) UNDERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_page_fetch_scheduler.sv
// Self-checking bench for page_fetch_scheduler: randomized fetch sequences
// against a bank/address model derived from the access rules.
module tb_page_fetch_scheduler;

  localparam logic [2:0] A_RST  = 3'b000;
  localparam logic [2:0] A_STBY = 3'b001;
  localparam logic [2:0] A_IDLE = 3'b100;
  localparam logic [2:0] A_BOOT = 3'b110;
  localparam logic [2:0] A_USER = 3'b111;
  localparam logic [12:0] NONE  = 13'h1FFF;
  localparam logic [11:0] BOOTA = 12'd0;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  acctype = 3'b000;
  logic [11:0] abspos = 12'd0;
  logic [12:0] bout = 13'h1FFF;
  logic        ack = 1'b0;
  logic        done = 1'b0;
  logic        fetch_req, fetch_type, fetch_bank, read_bank, buf_valid, underrun;
  logic [11:0] fetch_addr;

  int total = 0;
  int bad = 0;
  int issues = 0;           // fetches issued since reset
  logic exp_read_bank = 1'b0;

  page_fetch_scheduler #(
    .TIMEOUT_CYC (16'd100),
    .BOOT_ADDR   (BOOTA)
  ) dut (
    .MCLK         (mclk),
    .RST          (rst),
    .ACCTYPE      (acctype),
    .ABSPOS       (abspos),
    .BOUTCYCLENUM (bout),
    .FETCH_REQ    (fetch_req),
    .FETCH_TYPE   (fetch_type),
    .FETCH_ADDR   (fetch_addr),
    .FETCH_BANK   (fetch_bank),
    .FETCH_ACK    (ack),
    .FETCH_DONE   (done),
    .READ_BANK    (read_bank),
    .BUF_VALID    (buf_valid),
    .UNDERRUN     (underrun)
  );

  always #5 mclk = ~mclk;

  // Bank written by the n-th fetch after reset: reset leaves 1, each fetch toggles.
  function automatic logic bank_of(input int n);
    return (n % 2 == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic go_acc(input logic [2:0] v);
    acctype = v;
    tick();
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; acctype = A_RST;
    repeat (2) tick();
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL rst_req act=%0b exp=0", fetch_req); end
    total++; if (fetch_type !== 1'b0) begin bad++; $display("FAIL rst_type act=%0b exp=0", fetch_type); end
    total++; if (fetch_addr !== BOOTA) begin bad++; $display("FAIL rst_addr act=%0d exp=%0d", fetch_addr, BOOTA); end
    total++; if (fetch_bank !== 1'b1) begin bad++; $display("FAIL rst_bank act=%0b exp=1", fetch_bank); end
    total++; if (read_bank !== 1'b0) begin bad++; $display("FAIL rst_read_bank act=%0b exp=0", read_bank); end
    total++; if (buf_valid !== 1'b0) begin bad++; $display("FAIL rst_buf_valid act=%0b exp=0", buf_valid); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun act=%0b exp=0", underrun); end
    rst = 1'b0;
    tick();
    issues = 0;
    exp_read_bank = 1'b0;
  endtask

  task automatic test_boot();
    int hold;
    go_acc(A_STBY);
    go_acc(A_BOOT);
    issues++;
    total++; if (fetch_req !== 1'b1) begin bad++; $display("FAIL boot_req act=%0b exp=1", fetch_req); end
    total++; if (fetch_type !== 1'b0) begin bad++; $display("FAIL boot_type act=%0b exp=0", fetch_type); end
    total++; if (fetch_addr !== BOOTA) begin bad++; $display("FAIL boot_addr act=%0d exp=%0d", fetch_addr, BOOTA); end
    total++; if (fetch_bank !== 1'b0) begin bad++; $display("FAIL boot_bank act=%0b exp=0", fetch_bank); end
    hold = $urandom_range(1, 4);
    repeat (hold) tick();
    total++; if (fetch_req !== 1'b1 || fetch_addr !== BOOTA) begin bad++; $display("FAIL boot_hold act=%0b/%0d exp=1/%0d", fetch_req, fetch_addr, BOOTA); end
    pulse_ack();
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL boot_req_drop act=%0b exp=0", fetch_req); end
    repeat ($urandom_range(1, 5)) tick();
    total++; if (buf_valid !== 1'b0) begin bad++; $display("FAIL boot_wait_valid act=%0b exp=0", buf_valid); end
    pulse_done();
    exp_read_bank = bank_of(issues);
    total++; if (read_bank !== 1'b0) begin bad++; $display("FAIL boot_read_bank act=%0b exp=0", read_bank); end
    total++; if (buf_valid !== 1'b1) begin bad++; $display("FAIL boot_buf_valid act=%0b exp=1", buf_valid); end
  endtask

  task automatic test_page();
    logic [11:0] a;
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 12'd1234 : 12'($urandom_range(0, 4095));
      go_acc(A_IDLE);
      abspos = a;
      go_acc(A_USER);
      issues++;
      total++; if (fetch_req !== 1'b1 || fetch_type !== 1'b1) begin bad++; $display("FAIL page_req_type i=%0d act=%0b/%0b exp=1/1", i, fetch_req, fetch_type); end
      total++; if (fetch_addr !== a) begin bad++; $display("FAIL page_addr i=%0d act=%0d exp=%0d", i, fetch_addr, a); end
      total++; if (fetch_bank !== bank_of(issues)) begin bad++; $display("FAIL page_bank i=%0d act=%0b exp=%0b", i, fetch_bank, bank_of(issues)); end
      abspos = ~a;
      tick();
      total++; if (fetch_addr !== a) begin bad++; $display("FAIL page_addr_hold i=%0d act=%0d exp=%0d", i, fetch_addr, a); end
      pulse_ack();
      repeat ($urandom_range(0, 4)) tick();
      pulse_done();
      exp_read_bank = bank_of(issues);
      total++; if (read_bank !== exp_read_bank || buf_valid !== 1'b1) begin bad++; $display("FAIL page_commit i=%0d act=%0b/%0b exp=%0b/1", i, read_bank, buf_valid, exp_read_bank); end
    end
  endtask

  task automatic test_pending();
    int extra = 0;
    go_acc(A_IDLE);
    abspos = 12'($urandom_range(0, 2052));
    go_acc(A_USER);
    issues++;
    pulse_ack();
    go_acc(A_IDLE);
    abspos = 12'd7;
    go_acc(A_USER);
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL pend_busy_req act=%0b exp=0", fetch_req); end
    go_acc(A_IDLE);
    abspos = 12'd9;
    go_acc(A_USER);
    pulse_done();
    exp_read_bank = bank_of(issues);
    total++; if (read_bank !== exp_read_bank || buf_valid !== 1'b1 || fetch_req !== 1'b0) begin bad++; $display("FAIL pend_first_done act=%0b/%0b/%0b exp=%0b/1/0", read_bank, buf_valid, fetch_req, exp_read_bank); end
    tick();
    issues++;
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 12'd9 || fetch_type !== 1'b1) begin bad++; $display("FAIL pend_issue act=%0b/%0d/%0b exp=1/9/1", fetch_req, fetch_addr, fetch_type); end
    total++; if (fetch_bank !== bank_of(issues) || buf_valid !== 1'b0) begin bad++; $display("FAIL pend_bank act=%0b/%0b exp=%0b/0", fetch_bank, buf_valid, bank_of(issues)); end
    pulse_ack();
    pulse_done();
    exp_read_bank = bank_of(issues);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (fetch_req !== 1'b0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL pend_extra_req act=%0d exp=0", extra); end
  endtask

  task automatic test_underrun();
    bout = 13'($urandom_range(0, 13'h1FFE));
    tick();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL und_valid_buf act=%0b exp=0", underrun); end
    bout = NONE;
    tick();
    go_acc(A_IDLE);
    abspos = 12'($urandom_range(0, 4095));
    go_acc(A_USER);
    issues++;
    bout = 13'd0;
    tick();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL und_set act=%0b exp=1", underrun); end
    bout = NONE;
    pulse_ack();
    pulse_done();
    exp_read_bank = bank_of(issues);
    total++; if (underrun !== 1'b1 || buf_valid !== 1'b1) begin bad++; $display("FAIL und_sticky act=%0b/%0b exp=1/1", underrun, buf_valid); end
    go_acc(A_RST);
    total++; if (underrun !== 1'b0 || buf_valid !== 1'b0) begin bad++; $display("FAIL und_clear act=%0b/%0b exp=0/0", underrun, buf_valid); end
  endtask

  task automatic test_abort();
    int extra = 0;
    go_acc(A_IDLE);
    abspos = 12'($urandom_range(0, 4095));
    go_acc(A_USER);
    issues++;
    pulse_ack();
    go_acc(A_RST);
    repeat ($urandom_range(0, 3)) tick();
    pulse_done();
    total++; if (read_bank !== exp_read_bank || buf_valid !== 1'b0) begin bad++; $display("FAIL abort_wait act=%0b/%0b exp=%0b/0", read_bank, buf_valid, exp_read_bank); end
    // Abort while a second trigger is parked: parked trigger must vanish.
    go_acc(A_IDLE);
    go_acc(A_USER);
    issues++;
    go_acc(A_IDLE);
    go_acc(A_USER);
    go_acc(A_RST);
    ack = 1'b1; done = 1'b1; tick(); ack = 1'b0; done = 1'b0;
    total++; if (read_bank !== exp_read_bank || buf_valid !== 1'b0) begin bad++; $display("FAIL abort_req act=%0b/%0b exp=%0b/0", read_bank, buf_valid, exp_read_bank); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (fetch_req !== 1'b0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL abort_pend_cleared act=%0d exp=0", extra); end
    // Ack and done together: straight back to idle.
    go_acc(A_IDLE);
    go_acc(A_USER);
    issues++;
    ack = 1'b1; done = 1'b1; tick(); ack = 1'b0; done = 1'b0;
    exp_read_bank = bank_of(issues);
    total++; if (fetch_req !== 1'b0 || buf_valid !== 1'b1 || read_bank !== exp_read_bank) begin bad++; $display("FAIL ackdone act=%0b/%0b/%0b exp=0/1/%0b", fetch_req, buf_valid, read_bank, exp_read_bank); end
    go_acc(A_IDLE);
    go_acc(A_USER);
    issues++;
    total++; if (fetch_req !== 1'b1 || fetch_bank !== bank_of(issues)) begin bad++; $display("FAIL ackdone_idle act=%0b/%0b exp=1/%0b", fetch_req, fetch_bank, bank_of(issues)); end
    pulse_ack();
    pulse_done();
    exp_read_bank = bank_of(issues);
  endtask

  task automatic test_wait_timeout();
    int errs = 0;
    logic exp_u;
    go_acc(A_IDLE);
    go_acc(A_USER);
    issues++;
    pulse_ack();
    for (int k = 1; k <= 150; k++) begin
      tick();
`ifdef PFS_FETCH_TIMEOUT_EN
      exp_u = (k >= 100);
`else
      exp_u = 1'b0;
`endif
      if (underrun !== exp_u || fetch_req !== 1'b0 || buf_valid !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL long_wait bad_cycles act=%0d exp=0", errs); end
    pulse_done();
`ifdef PFS_FETCH_TIMEOUT_EN
    total++; if (buf_valid !== 1'b0 || read_bank !== exp_read_bank) begin bad++; $display("FAIL err_late_done act=%0b/%0b exp=0/%0b", buf_valid, read_bank, exp_read_bank); end
    go_acc(A_RST);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL err_exit act=%0b exp=0", underrun); end
`else
    exp_read_bank = bank_of(issues);
    total++; if (buf_valid !== 1'b1 || read_bank !== exp_read_bank) begin bad++; $display("FAIL long_wait_done act=%0b/%0b exp=1/%0b", buf_valid, read_bank, exp_read_bank); end
`endif
  endtask

  task automatic test_back_to_back();
    logic        is_boot;
    logic [11:0] a;
    for (int i = 0; i < 8; i++) begin
      is_boot = ($urandom_range(0, 2) == 0);
      a = 12'($urandom_range(0, 4095));
      go_acc(A_IDLE);
      abspos = a;
      go_acc(is_boot ? A_BOOT : A_USER);
      issues++;
      total++; if (fetch_req !== 1'b1 || fetch_type !== !is_boot || fetch_addr !== (is_boot ? BOOTA : a) || fetch_bank !== bank_of(issues)) begin
        bad++; $display("FAIL b2b_issue i=%0d act=%0b/%0b/%0d/%0b exp=1/%0b/%0d/%0b", i, fetch_req, fetch_type, fetch_addr, fetch_bank, !is_boot, is_boot ? BOOTA : a, bank_of(issues));
      end
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 2) == 0) begin
        ack = 1'b1; done = 1'b1; tick(); ack = 1'b0; done = 1'b0;
      end else begin
        pulse_ack();
        repeat ($urandom_range(0, 3)) tick();
        pulse_done();
      end
      exp_read_bank = bank_of(issues);
      total++; if (read_bank !== exp_read_bank || buf_valid !== 1'b1 || fetch_req !== 1'b0) begin bad++; $display("FAIL b2b_commit i=%0d act=%0b/%0b/%0b exp=%0b/1/0", i, read_bank, buf_valid, fetch_req, exp_read_bank); end
    end
  endtask

  task automatic test_async_reset();
    go_acc(A_IDLE);
    go_acc(A_USER);
    #2;
    rst = 1'b1;
    #1;
    total++; if (fetch_req !== 1'b0 || fetch_bank !== 1'b1 || fetch_addr !== BOOTA || fetch_type !== 1'b0) begin bad++; $display("FAIL async_rst_fetch act=%0b/%0b/%0d/%0b exp=0/1/%0d/0", fetch_req, fetch_bank, fetch_addr, fetch_type, BOOTA); end
    total++; if (read_bank !== 1'b0 || buf_valid !== 1'b0 || underrun !== 1'b0) begin bad++; $display("FAIL async_rst_out act=%0b/%0b/%0b exp=0/0/0", read_bank, buf_valid, underrun); end
    acctype = A_RST;
    repeat (2) tick();
    rst = 1'b0;
    issues = 0;
    exp_read_bank = 1'b0;
    tick();
    go_acc(A_STBY);
    go_acc(A_BOOT);
    issues++;
    total++; if (fetch_req !== 1'b1 || fetch_bank !== 1'b0) begin bad++; $display("FAIL first_bank act=%0b/%0b exp=1/0", fetch_req, fetch_bank); end
    pulse_ack();
    pulse_done();
    total++; if (read_bank !== 1'b0 || buf_valid !== 1'b1) begin bad++; $display("FAIL first_commit act=%0b/%0b exp=0/1", read_bank, buf_valid); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_page();
    test_pending();
    test_underrun();
    test_abort();
    test_wait_timeout();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
